// File: rtl/stepper_phase_decoder.sv
// Half-step coil bus monitor: synchronise, debounce, decode phase, track position/period.
// Optional err_count output is enabled by defining STEPPER_PHASE_DECODE_ERR_COUNT_EN.
module stepper_phase_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int PERIOD_W      = 32
) (
  input  logic                fab_clk,
  input  logic                reset,
  input  logic [3:0]          coil_in,
  input  logic                position_load,
  input  logic [15:0]         position_load_value,
  input  logic                error_clear,
  output logic [15:0]         position,
  output logic                step_strobe,
  output logic                step_dir,
  output logic [PERIOD_W-1:0] step_period,
  output logic                period_valid,
  output logic [2:0]          coil_phase,
  output logic                locked,
  output logic                illegal_err,
  output logic                skip_err
`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [7:0]          FC      = 8'(FILTER_CYCLES);
  localparam logic [PERIOD_W-1:0] PER_MAX = '1;

  // ---------------- input synchroniser + glitch filter ----------------
  logic [3:0] sync1_q, sync2_q, prev_q, filt_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic       same, accept, new_evt_q;

  // fcnt counts consecutive identical samples and parks at FC; accept fires
  // only on the cycle the run first reaches FC.
  always_comb begin
    same   = (sync2_q == prev_q);
    fcnt_d = 8'd1;
    if (same) fcnt_d = (fcnt_q == FC) ? fcnt_q : fcnt_q + 8'd1;
    accept = (fcnt_d == FC) && !(same && (fcnt_q == FC));
  end

  always_ff @(posedge fab_clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      filt_q    <= '0;
      fcnt_q    <= '0;
      new_evt_q <= 1'b0;
    end else begin
      sync1_q   <= coil_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      fcnt_q    <= fcnt_d;
      new_evt_q <= accept && (sync2_q != filt_q);
      if (accept) filt_q <= sync2_q;
    end
  end

  // ---------------- phase decode ----------------
  function automatic logic [3:0] decode(input logic [3:0] p);
    case (p)
      4'b1000: decode = {1'b1, 3'd0};
      4'b1100: decode = {1'b1, 3'd1};
      4'b0100: decode = {1'b1, 3'd2};
      4'b0110: decode = {1'b1, 3'd3};
      4'b0010: decode = {1'b1, 3'd4};
      4'b0011: decode = {1'b1, 3'd5};
      4'b0001: decode = {1'b1, 3'd6};
      4'b1001: decode = {1'b1, 3'd7};
      default: decode = 4'b0000;
    endcase
  endfunction

  state_e              state_q;
  logic [15:0]         position_q;
  logic                step_strobe_q, step_dir_q, period_valid_q, step_seen_q;
  logic [PERIOD_W-1:0] step_period_q, per_cnt_q;
  logic [2:0]          coil_phase_q;
  logic                illegal_q, skip_q;

  logic       legal, is_locked;
  logic [2:0] new_phase, delta;
  logic       ill_ev, lock_ev, fwd_ev, bwd_ev, skip_ev;

  assign {legal, new_phase} = decode(filt_q);
  assign delta     = new_phase - coil_phase_q;
  assign is_locked = (state_q == LOCKED);
  assign ill_ev    = new_evt_q & ~legal;
  assign lock_ev   = new_evt_q & legal & ~is_locked;
  assign fwd_ev    = new_evt_q & legal & is_locked & (delta == 3'd1);
  assign bwd_ev    = new_evt_q & legal & is_locked & (delta == 3'd7);
  assign skip_ev   = new_evt_q & legal & is_locked & (delta >= 3'd2) & (delta <= 3'd6);

  // ---------------- tracking FSM ----------------
  always_ff @(posedge fab_clk) begin
    if (reset) begin
      state_q        <= UNLOCKED;
      position_q     <= '0;
      step_strobe_q  <= 1'b0;
      step_dir_q     <= 1'b0;
      step_period_q  <= '0;
      period_valid_q <= 1'b0;
      step_seen_q    <= 1'b0;
      per_cnt_q      <= '0;
      coil_phase_q   <= '0;
      illegal_q      <= 1'b0;
      skip_q         <= 1'b0;
    end else begin
      step_strobe_q <= fwd_ev | bwd_ev;
      illegal_q     <= (illegal_q & ~error_clear) | ill_ev;
      skip_q        <= (skip_q & ~error_clear) | skip_ev;
      if (is_locked && (per_cnt_q != PER_MAX)) per_cnt_q <= per_cnt_q + 1'b1;

      case (state_q)
        UNLOCKED: begin
          if (lock_ev) begin
            state_q      <= LOCKED;
            coil_phase_q <= new_phase;
            per_cnt_q    <= '0;
            step_seen_q  <= 1'b0;
          end
        end
        LOCKED: begin
          if (ill_ev) begin
            state_q        <= UNLOCKED;
            period_valid_q <= 1'b0;
            step_seen_q    <= 1'b0;
          end else if (skip_ev) begin
            coil_phase_q <= new_phase;
          end else if (fwd_ev || bwd_ev) begin
            coil_phase_q  <= new_phase;
            step_dir_q    <= fwd_ev;
            position_q    <= fwd_ev ? position_q + 16'd1 : position_q - 16'd1;
            step_period_q <= (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 1'b1;
            per_cnt_q     <= '0;
            step_seen_q   <= 1'b1;
            if (step_seen_q) period_valid_q <= 1'b1;
          end
        end
        default: state_q <= UNLOCKED;
      endcase

      // A load overrides any step increment in the same cycle.
      if (position_load) position_q <= position_load_value;
    end
  end

  assign position     = position_q;
  assign step_strobe  = step_strobe_q;
  assign step_dir     = step_dir_q;
  assign step_period  = step_period_q;
  assign period_valid = period_valid_q;
  assign coil_phase   = coil_phase_q;
  assign locked       = is_locked;
  assign illegal_err  = illegal_q;
  assign skip_err     = skip_q;

`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
  logic [7:0] err_cnt_q;
  logic       err_ev;
  assign err_ev = ill_ev | skip_ev;

  always_ff @(posedge fab_clk) begin
    if (reset)                              err_cnt_q <= '0;
    else if (error_clear)                   err_cnt_q <= {7'd0, err_ev};
    else if (err_ev && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Scoreboard bench for stepper_phase_decoder: stimulus queues expected strobes, monitor checks them.
module tb_stepper_phase_decoder;

  logic        fab_clk = 1'b0;
  logic        reset;
  logic [3:0]  coil_in;
  logic        position_load;
  logic [15:0] position_load_value;
  logic        error_clear;
  logic [15:0] position;
  logic        step_strobe, step_dir, period_valid, locked, illegal_err, skip_err;
  logic [31:0] step_period;
  logic [2:0]  coil_phase;
`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  stepper_phase_decoder #(.FILTER_CYCLES(4), .PERIOD_W(32)) dut (
    .fab_clk(fab_clk), .reset(reset), .coil_in(coil_in),
    .position_load(position_load), .position_load_value(position_load_value),
    .error_clear(error_clear), .position(position), .step_strobe(step_strobe),
    .step_dir(step_dir), .step_period(step_period), .period_valid(period_valid),
    .coil_phase(coil_phase), .locked(locked), .illegal_err(illegal_err),
    .skip_err(skip_err)
`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 fab_clk = ~fab_clk;

  int unsigned cyc = 0;
  always @(posedge fab_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;
    logic [31:0] per;
    logic        pv;
    logic [2:0]  ph;
    logic [31:0] at;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int unsigned drive_cyc;

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge fab_clk) begin
    if (!reset && step_strobe) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("strobe_cycle", 32'(cyc), e.at);
        chk("strobe_position", 32'(position), 32'(e.pos));
        chk("strobe_dir", 32'(step_dir), 32'(e.dir));
        chk("strobe_period", step_period, e.per);
        chk("strobe_period_valid", 32'(period_valid), 32'(e.pv));
        chk("strobe_phase", 32'(coil_phase), 32'(e.ph));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fab_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p);
    coil_in   = p;
    drive_cyc = cyc;
  endtask

  // Strobe expected 2 sync + 4 filter + 1 FSM cycles after the drive.
  task automatic expect_step(input logic [15:0] pos, input logic dir,
                             input logic [31:0] per, input logic pv, input logic [2:0] ph);
    exp_t x;
    x.pos = pos; x.dir = dir; x.per = per; x.pv = pv; x.ph = ph;
    x.at  = 32'(drive_cyc + 7);
    sbq.push_back(x);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_position"}, 32'(position), 32'd0);
    chk({nm, "_flags"}, 32'({step_strobe, step_dir, period_valid, locked, illegal_err, skip_err}), 32'd0);
    chk({nm, "_phase"}, 32'(coil_phase), 32'd0);
    chk({nm, "_period"}, step_period, 32'd0);
`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
    chk({nm, "_err_count"}, 32'(err_count), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; coil_in = 4'b0000; position_load = 1'b0;
    position_load_value = 16'h0; error_clear = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Lock on phase 0, no step.
    drive(4'b1000);
    tick(6);
    chk("lock_not_early", 32'(locked), 32'd0);
    tick(1);
    chk("lock", 32'(locked), 32'd1);
    chk("lock_phase", 32'(coil_phase), 32'd0);
    chk("lock_position", 32'(position), 32'd0);
    tick(13);

    // Two forward steps 20 cycles apart.
    drive(4'b1100); expect_step(16'd1, 1'b1, 32'd20, 1'b0, 3'd1); tick(20);
    drive(4'b0100); expect_step(16'd2, 1'b1, 32'd20, 1'b1, 3'd2); tick(20);

    // Back down to 0, then wrap below zero.
    drive(4'b1100); expect_step(16'd1,     1'b0, 32'd20, 1'b1, 3'd1); tick(20);
    drive(4'b1000); expect_step(16'd0,     1'b0, 32'd20, 1'b1, 3'd0); tick(20);
    drive(4'b1001); expect_step(16'hFFFF,  1'b0, 32'd20, 1'b1, 3'd7); tick(10);
    position_load = 1'b1; position_load_value = 16'h7FFF;
    tick(1);
    position_load = 1'b0;
    chk("load_7fff", 32'(position), 32'h7FFF);
    tick(9);
    drive(4'b1000); expect_step(16'h8000, 1'b1, 32'd20, 1'b1, 3'd0); tick(20);

    // 3-cycle glitch is filtered out.
    drive(4'b1100); tick(3);
    drive(4'b1000); tick(17);
    chk("glitch_position", 32'(position), 32'h8000);
    chk("glitch_phase", 32'(coil_phase), 32'd0);

    // Phase skip 0 -> 4, then an illegal pattern.
    drive(4'b0010); tick(20);
    chk("skip_err", 32'(skip_err), 32'd1);
    chk("skip_phase", 32'(coil_phase), 32'd4);
    chk("skip_position", 32'(position), 32'h8000);
    chk("skip_still_locked", 32'(locked), 32'd1);
    chk("skip_no_illegal", 32'(illegal_err), 32'd0);
    drive(4'b1010); tick(20);
    chk("illegal_err", 32'(illegal_err), 32'd1);
    chk("illegal_unlock", 32'(locked), 32'd0);
    chk("illegal_pv_clear", 32'(period_valid), 32'd0);
    chk("illegal_phase_hold", 32'(coil_phase), 32'd4);
`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
    chk("err_count_2", 32'(err_count), 32'd2);
`endif
    error_clear = 1'b1; tick(1); error_clear = 1'b0;
    chk("clear_errors", 32'({illegal_err, skip_err}), 32'd0);
`ifdef STEPPER_PHASE_DECODE_ERR_COUNT_EN
    chk("err_count_cleared", 32'(err_count), 32'd0);
`endif

    // Load while unlocked, relock, step to 5, then reset mid-run.
    position_load = 1'b1; position_load_value = 16'd3; tick(1); position_load = 1'b0;
    chk("load_unlocked", 32'(position), 32'd3);
    drive(4'b1000); tick(20);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_position", 32'(position), 32'd3);
    drive(4'b1100); expect_step(16'd4, 1'b1, 32'd20, 1'b0, 3'd1); tick(20);
    drive(4'b0100); expect_step(16'd5, 1'b1, 32'd20, 1'b1, 3'd2); tick(20);
    chk("pre_reset_position", 32'(position), 32'd5);
    reset = 1'b1; tick(1);
    chk_all_zero("midreset");
    reset = 1'b0; tick(20);
    chk("post_reset_lock", 32'(locked), 32'd1);
    chk("post_reset_phase", 32'(coil_phase), 32'd2);

    // Load coincides with a forward step: load value wins, strobe still pulses.
    drive(4'b0110); expect_step(16'h1234, 1'b1, 32'd20, 1'b0, 3'd3);
    tick(6);
    position_load = 1'b1; position_load_value = 16'h1234;
    tick(1);
    position_load = 1'b0;
    tick(20);
    chk("load_step_position", 32'(position), 32'h1234);

    tick(5);
    chk("pending_strobes", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
